// File: rtl/capture_reg_arbiter_if.sv
// Requester/consumer bundle for the shared capture register.
// Requesters drive req/din/rel; the arbiter returns grant and captured data.
interface capture_reg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] din;
  logic                   rel;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic [IW-1:0]          owner;
  logic                   busy;

  modport master (
    output req, din, rel,
    input  gnt, q, q_valid, owner, busy
  );

  modport slave (
    input  req, din, rel,
    output gnt, q, q_valid, owner, busy
  );
endinterface

// File: rtl/capture_reg_arbiter.sv
// Round-robin owner of one shared capture register.
// Winner's data is captured, held valid for a window, then freed.
module capture_reg_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  capture_reg_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;

  logic             win_hit;
  logic [IW-1:0]    win_idx;

  // Round-robin pick: first requester at or after ptr_q, wrapping.
  always_comb begin
    int j;
    logic [IW-1:0] ji;
    j       = 0;
    ji      = '0;
    win_hit = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j  = (int'(ptr_q) + k) % N_REQ;
      ji = IW'(j);
      if (!win_hit && bus.req[ji]) begin
        win_hit = 1'b1;
        win_idx = ji;
      end
    end
  end

  // Next state: capture from IDLE, count down or release in HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    q_d     = q_q;
    owner_d = owner_q;
    gnt_d   = '0;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_hit) begin
          state_d = S_HOLD;
          cnt_d   = CW'(HOLD_CYCLES - 1);
          ptr_d   = (win_idx == IW'(N_REQ - 1))
                    ? '0 : win_idx + 1'b1;
          q_d     = bus.din[win_idx*WIDTH +: WIDTH];
          owner_d = win_idx;
          gnt_d   = N_REQ'(1) << win_idx;
          valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.rel || cnt_q == '0) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      q_q     <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.q       = q_q;
  assign bus.q_valid = valid_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = valid_q;
endmodule

// File: tb/tb_capture_reg_arbiter.sv
// Bench for capture_reg_arbiter: HOLD_CYCLES=3 and HOLD_CYCLES=1 copies
// driven in parallel, compared against a transaction-level model.
module tb_capture_reg_arbiter;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int HOLD0 = 3;
  localparam int HOLD1 = 1;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N*W-1:0] din;
  logic         rel;

  int errors = 0;
  int checks = 0;

  capture_reg_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus0 ();
  capture_reg_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus1 ();

  assign bus0.req = req;
  assign bus0.din = din;
  assign bus0.rel = rel;
  assign bus1.req = req;
  assign bus1.din = din;
  assign bus1.rel = rel;

  capture_reg_arbiter #(
    .N_REQ(N), .WIDTH(W), .HOLD_CYCLES(HOLD0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  capture_reg_arbiter #(
    .N_REQ(N), .WIDTH(W), .HOLD_CYCLES(HOLD1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per unit, is a capture live, how many valid cycles so far.
  bit         m_busy [2];
  int         m_age  [2];
  int         m_ptr  [2];
  int         m_owner[2];
  logic [7:0] m_q    [2];
  logic [3:0] m_gnt  [2];

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_busy[u] = 0; m_age[u] = 0; m_ptr[u] = 0;
      m_owner[u] = 0; m_q[u] = '0; m_gnt[u] = '0;
    end
  endtask

  task automatic model_edge();
    for (int u = 0; u < 2; u++) begin
      int hold;
      int w;
      hold = (u == 0) ? HOLD0 : HOLD1;
      m_gnt[u] = '0;
      if (!m_busy[u]) begin
        w = rr_pick(req, m_ptr[u]);
        if (w >= 0) begin
          m_busy[u]  = 1;
          m_age[u]   = 1;
          m_gnt[u]   = 4'(1 << w);
          m_q[u]     = din[w*W +: W];
          m_owner[u] = w;
          m_ptr[u]   = (w + 1) % N;
        end
      end else if (rel || m_age[u] >= hold) begin
        m_busy[u] = 0;
      end else begin
        m_age[u]++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q0"},  32'(bus0.q),       32'(m_q[0]));
    chk({tag, ".v0"},  32'(bus0.q_valid), 32'(m_busy[0]));
    chk({tag, ".g0"},  32'(bus0.gnt),     32'(m_gnt[0]));
    chk({tag, ".o0"},  32'(bus0.owner),   32'(m_owner[0]));
    chk({tag, ".b0"},  32'(bus0.busy),    32'(m_busy[0]));
    chk({tag, ".q1"},  32'(bus1.q),       32'(m_q[1]));
    chk({tag, ".v1"},  32'(bus1.q_valid), 32'(m_busy[1]));
    chk({tag, ".g1"},  32'(bus1.gnt),     32'(m_gnt[1]));
    chk({tag, ".o1"},  32'(bus1.owner),   32'(m_owner[1]));
    chk({tag, ".b1"},  32'(bus1.busy),    32'(m_busy[1]));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_din(input int slot, input logic [7:0] v);
    din[slot*W +: W] = v;
  endtask

  logic [3:0] exp_rr [5] = '{4'b0001, 4'b0010, 4'b0100,
                             4'b1000, 4'b0001};
  logic [3:0] gq[$];
  int         tq[$];
  int         oq[$];
  logic       saw_g1;

  initial begin
    rst_n = 1'b1;
    req   = '0;
    din   = '0;
    rel   = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check_all("rst_rel");

    // Single request from requester 2.
    req = 4'b0100;
    set_din(2, 8'hA5);
    step("t2_cap");
    chk("t2_gnt", 32'(bus0.gnt), 32'h4);
    chk("t2_q", 32'(bus0.q), 32'hA5);
    chk("t2_own", 32'(bus0.owner), 32'd2);
    req = '0;
    step("t2_h1");
    chk("t2_gnt_off", 32'(bus0.gnt), 32'h0);
    step("t2_h2");
    chk("t2_v3", 32'(bus0.q_valid), 32'h1);
    step("t2_idle");
    chk("t2_vdrop", 32'(bus0.q_valid), 32'h0);

    // Asynchronous reset in the middle of a hold window.
    req = 4'b0001;
    set_din(0, 8'h5A);
    step("t1_cap");
    req = '0;
    step("t1_h");
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("t1_async");
    @(posedge clk);
    #1 check_all("t1_inrst");
    @(negedge clk) rst_n = 1'b1;

    // All four requesting: rotation from reset priority.
    req = 4'b1111;
    for (int s = 0; s < N; s++) set_din(s, 8'(8'h10 + s));
    for (int c = 1; c <= 17; c++) begin
      step("t3_rr");
      if (bus0.gnt != '0) begin
        gq.push_back(bus0.gnt);
        tq.push_back(c);
        oq.push_back(int'(bus0.owner));
      end
    end
    chk("t3_ngnt", 32'(gq.size()), 32'd5);
    for (int i = 0; i < gq.size() && i < 5; i++) begin
      chk("t3_order", 32'(gq[i]), 32'(exp_rr[i]));
      chk("t3_owner", 32'(oq[i]), 32'(i % N));
      if (i > 0) chk("t3_gap", 32'(tq[i] - tq[i-1]), 32'd4);
    end
    req = '0;
    for (int g = 0; g < 8 && (m_busy[0] || m_busy[1]); g++)
      step("t3_drain");
    chk("t3_idle", 32'(bus0.q_valid), 32'h0);

    // Early release in the second valid cycle.
    req = 4'b0010;
    set_din(1, 8'hC3);
    step("t4_cap");
    req = '0;
    step("t4_v2");
    rel = 1'b1;
    step("t4_rel");
    chk("t4_vdrop", 32'(bus0.q_valid), 32'h0);
    rel = 1'b0;
    req = 4'b1000;
    set_din(3, 8'h77);
    step("t4_next");
    chk("t4_gnt3", 32'(bus0.gnt), 32'h8);
    req = '0;
    for (int g = 0; g < 8 && (m_busy[0] || m_busy[1]); g++)
      step("t4_drain");

    // din changes during hold; rel while idle.
    req = 4'b0100;
    set_din(2, 8'h3C);
    step("t5_cap");
    req = '0;
    set_din(2, 8'hFF);
    step("t5_h1");
    chk("t5_q", 32'(bus0.q), 32'h3C);
    step("t5_h2");
    step("t5_idle");
    rel = 1'b1;
    step("t5_rel_idle");
    step("t5_rel_idle2");
    chk("t5_q_keep", 32'(bus0.q), 32'h3C);
    rel = 1'b0;

    // Request 1 appears only during hold, then withdraws.
    saw_g1 = 1'b0;
    req = 4'b0100;
    step("t6_cap");
    req = 4'b0010;
    step("t6_pulse");
    saw_g1 |= bus0.gnt[1] | bus1.gnt[1];
    req = '0;
    for (int c = 0; c < 6; c++) begin
      step("t6_wait");
      saw_g1 |= bus0.gnt[1] | bus1.gnt[1];
    end
    chk("t6_no_g1", 32'(saw_g1), 32'h0);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      din = $urandom;
      rel = ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
